// File: rtl/frame_feed_pkg.sv
// Shared types and width helpers for the frame feed sequencer.
package frame_feed_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_WAIT_INTR,
    ST_LINE,
    ST_PAD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int PEND_W = 2;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // The pixel counter serves both the prime burst and single lines.
  function automatic int pix_cnt_w(input int img_w, input int prime_lines);
    return cnt_w((prime_lines > 1 ? prime_lines : 1) * img_w);
  endfunction

  function automatic int line_cnt_w(input int img_h);
    return cnt_w(img_h);
  endfunction

  function automatic int out_cnt_w(input int img_w, input int img_h);
    return cnt_w(img_w * img_h);
  endfunction

endpackage

// File: rtl/intr_pending_ctr.sv
// Rising-edge detect on the datapath interrupt feeding a saturating pending count.
module intr_pending_ctr
  import frame_feed_pkg::*;
(
  input  logic              clk_sys,
  input  logic              rst_b,
  input  logic              clr,
  input  logic              en,
  input  logic              intr,
  input  logic              consume,
  output logic [PEND_W-1:0] pending,
  output logic              ovf
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic intr_q;
  logic intr_edge;

  assign intr_edge = intr & ~intr_q;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      intr_q  <= 1'b0;
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      intr_q <= intr;
      if (clr) begin
        pending <= '0;
        ovf     <= 1'b0;
      end else if (en) begin
        // An edge that coincides with a consume cancels it out.
        if (intr_edge && !consume && pending != PEND_MAX)
          pending <= pending + PEND_W'(1);
        else if (consume && !intr_edge)
          pending <= pending - PEND_W'(1);
        if (intr_edge && pending == PEND_MAX)
          ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_feed_ctrl.sv
// Streams one frame into the image datapath: primes the line buffers, releases
// one line per datapath interrupt, appends zero lines, then waits for all outputs.
//   state      | meaning
//   IDLE       | waiting for i_start
//   PRIME      | forwarding the first PRIME_LINES lines back-to-back
//   WAIT_INTR  | waiting for a pending line-free interrupt
//   LINE       | forwarding one source line
//   PAD        | emitting one zero line
//   DRAIN      | waiting for the last datapath output pixel
//   DONE       | one-cycle completion pulse
module frame_feed_ctrl
  import frame_feed_pkg::*;
#(
  parameter int IMG_W       = 512,
  parameter int IMG_H       = 512,
  parameter int PRIME_LINES = 4,
  parameter int PAD_LINES   = 2,
  parameter int DATA_W      = 8
)(
  input  logic                                  axi_clk,
  input  logic                                  axi_reset_n,
  input  logic                                  i_start,
  input  logic [DATA_W-1:0]                     s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [DATA_W-1:0]                     o_pix_data,
  output logic                                  o_pix_valid,
  input  logic                                  i_dp_ready,
  input  logic                                  i_dp_intr,
  input  logic                                  i_out_valid,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic [out_cnt_w(IMG_W, IMG_H)-1:0]    o_out_count,
  output logic                                  o_err_intr_ovf
);

  localparam int PRIME_BEATS = PRIME_LINES * IMG_W;
  localparam int OUT_TOTAL   = IMG_W * IMG_H;
  localparam int PIX_W       = pix_cnt_w(IMG_W, PRIME_LINES);
  localparam int LINE_W      = line_cnt_w(IMG_H);
  localparam int PAD_W       = cnt_w(PAD_LINES);
  localparam int OUT_W       = out_cnt_w(IMG_W, IMG_H);

  state_t              state;
  logic [PIX_W-1:0]    pix_cnt;
  logic [LINE_W-1:0]   lines_sent;
  logic [PAD_W-1:0]    pad_sent;
  logic [PEND_W-1:0]   pending;
  logic                accept;
  logic                pad_beat;
  logic                consume;
  logic                start_req;

  always_comb begin
    s_ready = 1'b0;
    if (i_dp_ready) begin
      if (state == ST_PRIME)
        s_ready = (pix_cnt < PIX_W'(PRIME_BEATS));
      else if (state == ST_LINE)
        s_ready = (pix_cnt < PIX_W'(IMG_W));
    end
  end

  assign accept    = s_valid && s_ready;
  assign pad_beat  = (state == ST_PAD) && i_dp_ready;
  assign consume   = (state == ST_WAIT_INTR) && (pending != '0);
  assign start_req = (state == ST_IDLE) && i_start;
  assign o_busy    = (state != ST_IDLE);
  assign o_done    = (state == ST_DONE);

  intr_pending_ctr u_intr_pending_ctr (
    .clk_sys (axi_clk),
    .rst_b   (axi_reset_n),
    .clr     (start_req),
    .en      (o_busy),
    .intr    (i_dp_intr),
    .consume (consume),
    .pending (pending),
    .ovf     (o_err_intr_ovf)
  );

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state       <= ST_IDLE;
      pix_cnt     <= '0;
      lines_sent  <= '0;
      pad_sent    <= '0;
      o_out_count <= '0;
      o_pix_valid <= 1'b0;
      o_pix_data  <= '0;
    end else begin
      o_pix_valid <= accept || pad_beat;
      if (accept)
        o_pix_data <= s_data;
      else if (pad_beat)
        o_pix_data <= '0;

      if (state != ST_IDLE && i_out_valid && o_out_count != OUT_W'(OUT_TOTAL))
        o_out_count <= o_out_count + OUT_W'(1);

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state       <= ST_PRIME;
            pix_cnt     <= '0;
            lines_sent  <= '0;
            pad_sent    <= '0;
            o_out_count <= '0;
          end
        end
        ST_PRIME: begin
          if (accept) begin
            if (pix_cnt == PIX_W'(PRIME_BEATS - 1)) begin
              pix_cnt    <= '0;
              lines_sent <= LINE_W'(PRIME_LINES);
              state      <= ST_WAIT_INTR;
            end else begin
              pix_cnt <= pix_cnt + PIX_W'(1);
            end
          end
        end
        ST_WAIT_INTR: begin
          if (pending != '0) begin
            if (lines_sent < LINE_W'(IMG_H))
              state <= ST_LINE;
            else if (pad_sent < PAD_W'(PAD_LINES))
              state <= ST_PAD;
            else
              state <= ST_DRAIN;
          end
        end
        ST_LINE: begin
          if (accept) begin
            if (pix_cnt == PIX_W'(IMG_W - 1)) begin
              pix_cnt    <= '0;
              lines_sent <= lines_sent + LINE_W'(1);
              state      <= ST_WAIT_INTR;
            end else begin
              pix_cnt <= pix_cnt + PIX_W'(1);
            end
          end
        end
        ST_PAD: begin
          if (pad_beat) begin
            if (pix_cnt == PIX_W'(IMG_W - 1)) begin
              pix_cnt  <= '0;
              pad_sent <= pad_sent + PAD_W'(1);
              state    <= ST_WAIT_INTR;
            end else begin
              pix_cnt <= pix_cnt + PIX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (o_out_count == OUT_W'(OUT_TOTAL))
            state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_feed_ctrl.md
# frame_feed_ctrl

Sequencer that streams one grayscale frame into the image-processing datapath, doing in hardware what the bench does today. Primes the line buffers with the first lines, then releases one line per datapath interrupt. Appends zero-valued padding lines and counts processed output pixels until the frame completes. Sits between the pixel source (DMA/FIFO stream) and the imageProcessTop slave port.

## Interface
- IMG_W, 512: pixels per line
- IMG_H, 512: lines per frame
- PRIME_LINES, 4: lines sent before the first interrupt wait
- PAD_LINES, 2: zero lines appended after the image
- DATA_W, 8: pixel width

- axi_clk  in  1  sole clock, rising edge
- axi_reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle frame start request
- s_data  in  DATA_W  source pixel
- s_valid  in  1  source pixel valid
- s_ready  out  1  source pixel accepted when s_valid && s_ready
- o_pix_data  out  DATA_W  pixel to datapath
- o_pix_valid  out  1  pixel valid to datapath
- i_dp_ready  in  1  datapath input ready
- i_dp_intr  in  1  datapath line-free interrupt (level; rising edge counts)
- i_out_valid  in  1  datapath output pixel valid
- o_busy  out  1  high outside IDLE
- o_done  out  1  one-cycle pulse at frame completion
- o_out_count  out  $clog2(IMG_W*IMG_H+1)  output pixels seen this frame
- o_err_intr_ovf  out  1  sticky: interrupt lost to pending-counter saturation

## Operation
- States: IDLE, PRIME, WAIT_INTR, LINE, PAD, DRAIN, DONE.
- IDLE: on i_start, clear counters and o_err_intr_ovf, go PRIME. i_start is ignored in every other state.
- PRIME: forward source pixels until PRIME_LINES*IMG_W have been accepted, then go WAIT_INTR.
- WAIT_INTR: when pending > 0, consume one pending interrupt.
  - Go LINE if lines_sent < IMG_H.
  - Otherwise go PAD if pad_sent < PAD_LINES.
  - Otherwise go DRAIN.
- LINE: forward exactly IMG_W source pixels, increment lines_sent, return to WAIT_INTR.
- PAD: s_ready = 0. Drive o_pix_data = 0 with o_pix_valid for IMG_W beats (each beat gated by i_dp_ready), increment pad_sent, return to WAIT_INTR.
- DRAIN: wait until o_out_count == IMG_W*IMG_H, then go DONE.
- DONE: o_done = 1 for one cycle, then return to IDLE. o_out_count holds until the next start.
- Pending-interrupt counter:
  - 2-bit, saturating at 3.
  - Incremented on each rising edge of i_dp_intr in any non-IDLE state.
  - An edge arriving while the counter is at 3 sets o_err_intr_ovf.
  - Edge and consume in the same cycle leave the counter unchanged.
- o_out_count increments on i_out_valid in any non-IDLE state and saturates at IMG_W*IMG_H.

## Timing
- Reset values: s_ready 0, o_pix_valid 0, o_pix_data 0, o_busy 0, o_done 0, o_out_count 0, o_err_intr_ovf 0. State is IDLE; all counters 0.
- s_ready is combinational: (PRIME or LINE) && i_dp_ready && line/prime pixel count not yet reached.
- o_pix_data/o_pix_valid are registered, 1-cycle latency from acceptance. o_pix_valid is low in any cycle with no acceptance or pad beat.
- No source pixels are accepted in WAIT_INTR, PAD, DRAIN or DONE. Pixels beyond the frame wait at the source.
- Interrupt edge detect uses one registered copy of i_dp_intr. An edge is visible as pending one cycle after it arrives, so WAIT_INTR exits at the earliest 2 cycles after the edge.
- Zero-wait run: PRIME_LINES*IMG_W beats back-to-back with s_valid and i_dp_ready held high.
- The last forwarded beat of a line and the state change to WAIT_INTR occur in the same cycle.
- Asynchronous reset mid-frame: immediate return to reset values. Partial line state is discarded; the source is not drained.

## Structure
- Shared package frame_feed_pkg holds:
  - the state enum;
  - width constants derived from IMG_W/IMG_H: pixel-count, line-count and out-count widths.
- One natural sub-module: intr_pending_ctr (edge detect, saturating counter, overflow flag).
- All other logic lives in the top.

## Test plan
- IMG_W=8, IMG_H=6, PRIME=4, PAD=2, all ready, bench pulses i_dp_intr 10 cycles after each WAIT_INTR entry and returns 48 out-valids:
  - 32 beats, then 8 beats per interrupt;
  - 2 zero lines of 8;
  - o_done exactly once; o_out_count = 48.
- i_dp_ready toggled every other cycle during PRIME -> 32 beats total, none duplicated or dropped, data order preserved.
- Four interrupt edges during PRIME -> pending saturates at 3 and o_err_intr_ovf = 1. Frame still completes using 3 pending interrupts plus later edges.
- i_start asserted while busy -> ignored, no counter reset. i_start in IDLE after DONE -> clean second frame with o_out_count restarting at 0.
- axi_reset_n asserted during LINE with 3 of 8 beats sent -> next cycle o_busy = 0, s_ready = 0, counts 0. A fresh start then primes 32 beats.
- Default 512x512 smoke run -> 262144 forwarded beats, 1024 pad beats, o_done after 262144 out-valids.
